// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: recovers digits/dps from a snooped 4-digit multiplexed seven-segment bus
module sseg_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 524288,
   parameter int CNT_W          = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic [3:0] dp_out,
   output logic [3:0] digit_valid,
   output logic       digit_upd,
   output logic       frame_done,
   output logic       seg_err,
   output logic       an_err,
   output logic       stale
);
   localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);
   logic [3:0]       r_an_s1, r_an_s2;
   logic [7:0]       r_sg_s1, r_sg_s2;
   logic [11:0]      r_prev;
   logic [CNT_W-1:0] r_stab, r_tcnt;
   logic [3:0][3:0]  r_hex;
   logic [3:0]       r_dp, r_valid, r_mask;
   logic             r_upd, r_frame, r_seg_err, r_an_err, r_stale;
   logic             w_same, w_cap, w_an_ok, w_an_idle, w_leg, w_to, w_seg_ok, w_blank;
   logic [1:0]       w_sel;
   logic [3:0]       w_nib, w_bit;

   assign w_same    = {r_an_s2, r_sg_s2} == r_prev;
   assign w_cap     = w_same && (r_stab == STAB_MAX - CNT_W'(1));
   assign w_an_idle = r_an_s2 == 4'hF;
   assign w_an_ok   = (r_an_s2 == 4'hE) || (r_an_s2 == 4'hD) || (r_an_s2 == 4'hB) || (r_an_s2 == 4'h7);
   assign w_sel     = !r_an_s2[0] ? 2'd0 : !r_an_s2[1] ? 2'd1 : !r_an_s2[2] ? 2'd2 : 2'd3;
   assign w_leg     = w_cap && w_an_ok;
   assign w_bit     = w_leg ? ~r_an_s2 : 4'h0;
   assign w_to      = !w_leg && (r_tcnt == TO_MAX - CNT_W'(1));
   assign w_blank   = r_sg_s2[6:0] == 7'b1111111;

   // map an active-low a..g pattern back to its hex nibble
   always_comb begin
      w_nib    = 4'h0;
      w_seg_ok = 1'b1;
      case (r_sg_s2[6:0])
         7'b0000001: w_nib = 4'h0;
         7'b1001111: w_nib = 4'h1;
         7'b0010010: w_nib = 4'h2;
         7'b0000110: w_nib = 4'h3;
         7'b1001100: w_nib = 4'h4;
         7'b0100100: w_nib = 4'h5;
         7'b0100000: w_nib = 4'h6;
         7'b0001111: w_nib = 4'h7;
         7'b0000000: w_nib = 4'h8;
         7'b0000100: w_nib = 4'h9;
         7'b0001000: w_nib = 4'hA;
         7'b1100000: w_nib = 4'hB;
         7'b0110001: w_nib = 4'hC;
         7'b1000010: w_nib = 4'hD;
         7'b0110000: w_nib = 4'hE;
         7'b0111000: w_nib = 4'hF;
         default:    w_seg_ok = 1'b0;
      endcase
   end

   // two-flop synchroniser and stability counter that fires once per stable window
   always_ff @(posedge clk) begin
      if (reset) begin
         r_an_s1 <= 4'hF;
         r_an_s2 <= 4'hF;
         r_sg_s1 <= 8'hFF;
         r_sg_s2 <= 8'hFF;
         r_prev  <= 12'hFFF;
         r_stab  <= '0;
      end else begin
         r_an_s1 <= an;
         r_an_s2 <= r_an_s1;
         r_sg_s1 <= sseg;
         r_sg_s2 <= r_sg_s1;
         r_prev  <= {r_an_s2, r_sg_s2};
         r_stab  <= !w_same ? '0 : (r_stab == STAB_MAX) ? r_stab : r_stab + CNT_W'(1);
      end
   end

   // capture handling, frame tracking and stale timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hex     <= '0;
         r_dp      <= 4'h0;
         r_valid   <= 4'h0;
         r_mask    <= 4'h0;
         r_tcnt    <= '0;
         r_upd     <= 1'b0;
         r_frame   <= 1'b0;
         r_seg_err <= 1'b0;
         r_an_err  <= 1'b0;
         r_stale   <= 1'b0;
      end else begin
         r_upd     <= 1'b0;
         r_seg_err <= 1'b0;
         r_an_err  <= w_cap && !w_an_ok && !w_an_idle;
         r_frame   <= r_mask == 4'hF;
         r_mask    <= w_to ? 4'h0 : (r_mask == 4'hF) ? w_bit : r_mask | w_bit;
         if (w_leg) begin
            r_tcnt  <= '0;
            r_stale <= 1'b0;
            if (w_seg_ok) begin
               r_hex[w_sel]   <= w_nib;
               r_dp[w_sel]    <= ~r_sg_s2[7];
               r_valid[w_sel] <= 1'b1;
               r_upd          <= 1'b1;
            end else begin
               r_valid[w_sel] <= 1'b0;
               r_seg_err      <= !w_blank;
            end
         end else if (r_tcnt != TO_MAX) begin
            r_tcnt <= r_tcnt + CNT_W'(1);
            if (w_to) begin
               r_stale <= 1'b1;
               r_valid <= 4'h0;
            end
         end
      end
   end

   assign hex0        = r_hex[0];
   assign hex1        = r_hex[1];
   assign hex2        = r_hex[2];
   assign hex3        = r_hex[3];
   assign dp_out      = r_dp;
   assign digit_valid = r_valid;
   assign digit_upd   = r_upd;
   assign frame_done  = r_frame;
   assign seg_err     = r_seg_err;
   assign an_err      = r_an_err;
   assign stale       = r_stale;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: directed checks of capture, framing, glitch filtering, errors, timeout and reset
module tb_sseg_scan_decoder;
   localparam int S = 16;
   localparam int T = 400;
   localparam logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                       7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] an;
   logic [7:0] sseg;
   logic [3:0] hex3, hex2, hex1, hex0, dp_out, digit_valid;
   logic       digit_upd, frame_done, seg_err, an_err, stale;
   int n_chk = 0, n_fail = 0;
   int n_upd = 0, n_frm = 0, n_serr = 0, n_aerr = 0;

   sseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(20)) dut (
      .clk(clk), .reset(reset), .an(an), .sseg(sseg),
      .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .dp_out(dp_out), .digit_valid(digit_valid), .digit_upd(digit_upd),
      .frame_done(frame_done), .seg_err(seg_err), .an_err(an_err), .stale(stale)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (digit_upd) n_upd++;
      if (frame_done) n_frm++;
      if (seg_err) n_serr++;
      if (an_err) n_aerr++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int d, input logic [3:0] v, input logic dp);
      an   = ~(4'b0001 << d);
      sseg = {~dp, SEG[v]};
   endtask

   initial begin
      int u, f, se, ae;
      reset = 1'b1;
      an    = 4'hF;
      sseg  = 8'hFF;
      tick(3);
      check("rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      check("rst_dp_valid", {dp_out, digit_valid}, 8'h00);
      check("rst_flags", {digit_upd, frame_done, seg_err, an_err, stale}, 5'b0);
      // single digit capture and its latency
      reset = 1'b0;
      u = n_upd;
      show(0, 4'h3, 1'b0);
      tick(2 + S);
      check("lat_before", digit_valid, 4'h0);
      tick(1);
      check("lat_hex0", hex0, 4'h3);
      check("lat_valid", {dp_out, digit_valid}, 8'h01);
      tick(11);
      check("lat_upd_cnt", n_upd - u, 1);
      // full frame scan
      f = n_frm;
      show(0, 4'h1, 1'b0); tick(64);
      show(1, 4'h2, 1'b0); tick(64);
      show(2, 4'hA, 1'b1); tick(64);
      show(3, 4'hF, 1'b0); tick(64);
      check("frm_hex", {hex3, hex2, hex1, hex0}, 16'hFA21);
      check("frm_dp", dp_out, 4'b0100);
      check("frm_valid", digit_valid, 4'hF);
      check("frm_done_cnt", n_frm - f, 1);
      // glitching segment bus never settles long enough
      u = n_upd; se = n_serr;
      for (int k = 0; k < 20; k++) begin
         an   = 4'hD;
         sseg = {1'b1, SEG[5]} ^ ((k % 2 == 1) ? 8'h08 : 8'h00);
         tick(5);
      end
      check("glt_upd", n_upd - u, 0);
      check("glt_serr", n_serr - se, 0);
      check("glt_hex1", hex1, 4'h2);
      sseg = {1'b1, SEG[5]};
      tick(30);
      check("glt_settle_upd", n_upd - u, 1);
      check("glt_settle_hex1", hex1, 4'h5);
      // illegal anode pattern
      u = n_upd; ae = n_aerr;
      an = 4'hC; sseg = {1'b1, SEG[8]};
      tick(40);
      check("an_err_cnt", n_aerr - ae, 1);
      check("an_err_upd", n_upd - u, 0);
      check("an_err_hex", {hex3, hex2, hex1, hex0}, 16'hFA51);
      check("an_err_valid", digit_valid, 4'hF);
      // undecodable segments on digit 3
      se = n_serr;
      an = 4'h7; sseg = 8'b1_1010101;
      tick(40);
      check("seg_err_cnt", n_serr - se, 1);
      check("seg_err_valid", digit_valid, 4'h7);
      check("seg_err_hex3", hex3, 4'hF);
      check("seg_err_upd", n_upd - u, 0);
      // refill the frame then freeze at idle until stale
      show(0, 4'h0, 1'b0); tick(40);
      show(1, 4'h1, 1'b0); tick(40);
      show(2, 4'h2, 1'b0); tick(40);
      show(3, 4'h3, 1'b0); tick(40);
      check("to_valid_pre", digit_valid, 4'hF);
      an = 4'hF; sseg = 8'hFF;
      tick(T - 22);
      check("to_stale_pre", stale, 1'b0);
      tick(1);
      check("to_stale", stale, 1'b1);
      check("to_valid", digit_valid, 4'h0);
      tick(50);
      check("to_stale_hold", stale, 1'b1);
      show(0, 4'h7, 1'b0);
      tick(2 + S);
      check("rs_stale_pre", stale, 1'b1);
      tick(1);
      check("rs_stale", stale, 1'b0);
      check("rs_valid", digit_valid, 4'h1);
      check("rs_hex0", hex0, 4'h7);
      // reset part way through a stability window
      tick(20);
      u = n_upd; f = n_frm; se = n_serr; ae = n_aerr;
      show(1, 4'h9, 1'b0);
      tick(13);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mr_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
      check("mr_dp_valid", {dp_out, digit_valid}, 8'h00);
      check("mr_flags", {digit_upd, frame_done, seg_err, an_err, stale}, 5'b0);
      tick(2 + S);
      check("mr_valid_pre", digit_valid, 4'h0);
      check("mr_pulses_pre", (n_upd - u) + (n_frm - f) + (n_serr - se) + (n_aerr - ae), 0);
      tick(1);
      check("mr_valid", digit_valid, 4'h2);
      check("mr_hex1", hex1, 4'h9);
      tick(5);
      check("mr_upd_cnt", n_upd - u, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit seven-segment interface: snoops the active-low anode enables `an` and the segment bus `sseg` driven by the display multiplexer.
- Reconstructs the four hex digits and decimal points shown on the display.
- Used for self-check and readback of displayed values.
- Inputs are treated as asynchronous pins, so the block synchronises them, filters glitches, decodes segment patterns back to nibbles and flags malformed or stalled scans.

Parameters:
- STABLE_CYCLES, 16, consecutive cycles synced an/sseg must stay unchanged before a capture (>=2).
- TIMEOUT_CYCLES, 524288, cycles with no capture before all digits are declared stale.
- CNT_W, 20, width of the stability and timeout counters; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- an  input  4  observed anode enables, active low.
- sseg  input  8  observed segments, active low; [7]=dp, [6:0]=a..g.
- hex3, hex2, hex1, hex0  output  4 each  decoded digit values.
- dp_out  output  4  decoded decimal points, bit i = digit i, 1 = lit (i.e. sseg[7]==0).
- digit_valid  output  4  bit i set when hex_i holds a decoded, non-stale value.
- digit_upd  output  1  one-cycle pulse on every capture.
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
- seg_err  output  1  one-cycle pulse on an undecodable segment pattern.
- an_err  output  1  one-cycle pulse on an illegal anode pattern.
- stale  output  1  high while the timeout has expired.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; synchroniser flops 4'hF / 8'hFF; counters 0; seen-mask 0.
- Synchronisation: two flops on an and sseg. All logic below uses the second stage.
- Stability counter:
  - Clears whenever the synced {an,sseg} differs from its value one cycle earlier; otherwise increments, saturating at STABLE_CYCLES.
  - A capture event fires on the single cycle the counter reaches STABLE_CYCLES, so there is one event per stable window.
  - Total latency from a pin change to the outputs is 2 + STABLE_CYCLES + 1 cycles.
- Anode classification at the capture event:
  - 1110, 1101, 1011, 0111 select digit 0, 1, 2, 3 respectively.
  - 1111 = idle: no action, no error.
  - Any other value: an_err pulse, no digit update.
- Segment decode of sseg[6:0] (active-low, bit 6 = a):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - 1111111 = blank: digit_valid[i] is cleared, hex_i is held, no error.
  - Any other pattern: seg_err pulse, digit_valid[i] cleared, hex_i held.
- Legal capture of digit i:
  - hex_i and dp_out[i] are registered.
  - digit_valid[i] is set.
  - digit_upd pulses.
  - Mask bit i is set.
  - The timeout counter clears.
  - Blank and undecodable captures on a legal anode also set mask bit i and clear the timeout.
- frame_done:
  - Pulses the cycle after the mask becomes 4'hF; the mask then clears.
  - A capture in that same cycle is recorded into the freshly cleared mask.
- Repeated capture of the same digit before the frame completes overwrites that digit; the mask is unchanged.
- Timeout:
  - The counter increments every cycle without a legal-anode capture.
  - On reaching TIMEOUT_CYCLES: stale=1, digit_valid=0, mask=0; the counter holds.
  - The next legal capture clears stale in the same cycle it sets that digit's valid bit.
- Error pulses and the update pulse are mutually exclusive per capture. At most one capture occurs per cycle.
- Reset mid-window discards any partial stability count; no pulse is emitted.

Test Plan:
- Reset, then drive an=1110, sseg=8'b1_0000110 held 30 cycles -> after 19 cycles hex0=3, dp_out[0]=0, digit_valid=0001, single digit_upd pulse.
- Cycle an through 1110/1101/1011/0111 with digits 1,2,A,F (dp on digit 2 via sseg[7]=0), 64 cycles each -> hex0..3 = 1,2,A,F, dp_out=0100, digit_valid=1111, exactly one frame_done after digit 3.
- Glitch: toggle sseg bit 3 every 5 cycles for 100 cycles with an=1101 -> no digit_upd, outputs unchanged; then hold stable -> one capture.
- an=1100 held 40 cycles -> one an_err pulse, no output change; sseg=1010101 on an=0111 -> one seg_err pulse, digit_valid[3]=0.
- Full frame captured, then inputs frozen at an=1111 for TIMEOUT_CYCLES -> stale=1, digit_valid=0000; resume scanning -> stale drops on first capture.
- Assert reset for 1 cycle mid-window (counter at 10) -> all outputs 0, no pulses, capture resumes only after a fresh stable window.
